// File: rtl/sqwave_gen.sv
// Multi-channel square/PWM generator with 1-2-5 period stepping and phase-spaced outputs.
// Define SQWAVE_DUTY_EN to enable duty control; otherwise duty is fixed at 50 %.
module sqwave_gen #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned INIT_PERIOD = 100_000_000,
  parameter int unsigned INIT_MANT   = 0,
  parameter int unsigned MIN_PERIOD  = 10,
  parameter int unsigned MAX_PERIOD  = 1_000_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic                freq_up_i,
  input  logic                freq_dn_i,
  input  logic                duty_up_i,
  input  logic                duty_dn_i,
  output logic [CHANNELS-1:0] wave_o,
  output logic [WIDTH-1:0]    period_o,
  output logic [1:0]          mant_o,
  output logic [3:0]          duty_o,
  output logic                limit_o
);

  localparam int unsigned XW = WIDTH + 3;

  typedef enum logic [1:0] {
    Mant1 = 2'd0,
    Mant2 = 2'd1,
    Mant5 = 2'd2
  } mant_e;

  localparam mant_e          InitMant = mant_e'(INIT_MANT[1:0]);
  localparam logic [WIDTH-1:0] InitP  = WIDTH'(INIT_PERIOD);
  localparam logic [WIDTH-1:0] InitH  = (INIT_PERIOD / 2 == 0) ? WIDTH'(1) :
                                        WIDTH'(INIT_PERIOD / 2);

  function automatic logic [WIDTH-1:0] calc_off(input logic [WIDTH-1:0] p,
                                                input int unsigned    k);
    logic [XW-1:0] prod;
    prod = XW'(p) * XW'(k);
    return WIDTH'(prod / XW'(CHANNELS));
  endfunction

  // Staged set
  logic [WIDTH-1:0] ps_q, ps_d;
  mant_e            mant_q, mant_d;
  logic             limit_q, limit_d;

  // Derived set: one-cycle registered snapshot of {P, H, OFF} from the staged values
  logic [WIDTH-1:0] dp_q, dp_d;
  logic [WIDTH-1:0] dh_q, dh_d;
  logic [WIDTH-1:0] doff_q [CHANNELS];
  logic [WIDTH-1:0] doff_d [CHANNELS];

  // Active set and counter
  logic [WIDTH-1:0]    p_q, p_d;
  logic [WIDTH-1:0]    h_q, h_d;
  logic [WIDTH-1:0]    off_q [CHANNELS];
  logic [WIDTH-1:0]    off_d [CHANNELS];
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [CHANNELS-1:0] wave_q, wave_d;

  // Period stepping
  logic [XW-1:0] ps_x, cand;
  mant_e         cand_mant;
  logic          step, reject;

  always_comb begin
    ps_x      = XW'(ps_q);
    cand      = ps_x;
    cand_mant = mant_q;
    step      = 1'b0;
    if (freq_up_i) begin
      step = 1'b1;
      unique case (mant_q)
        Mant1: begin cand = ps_x >> 1;             cand_mant = Mant5; end
        Mant5: begin cand = (ps_x << 1) / XW'(5);  cand_mant = Mant2; end
        Mant2: begin cand = ps_x >> 1;             cand_mant = Mant1; end
        default: step = 1'b0;
      endcase
    end else if (freq_dn_i) begin
      step = 1'b1;
      unique case (mant_q)
        Mant1: begin cand = ps_x << 1;                   cand_mant = Mant2; end
        Mant2: begin cand = ((ps_x << 2) + ps_x) >> 1;   cand_mant = Mant5; end
        Mant5: begin cand = ps_x << 1;                   cand_mant = Mant1; end
        default: step = 1'b0;
      endcase
    end
    reject  = step && ((cand < XW'(MIN_PERIOD)) || (cand > XW'(MAX_PERIOD)));
    limit_d = reject;
    ps_d    = ps_q;
    mant_d  = mant_q;
    if (step && !reject) begin
      ps_d   = cand[WIDTH-1:0];
      mant_d = cand_mant;
    end
  end

`ifdef SQWAVE_DUTY_EN
  logic [3:0]       ds_q, ds_d;
  logic [WIDTH+3:0] hprod, hq;

  always_comb begin
    ds_d = ds_q;
    if (duty_up_i) begin
      if (ds_q < 4'd9) ds_d = ds_q + 4'd1;
    end else if (duty_dn_i) begin
      if (ds_q > 4'd1) ds_d = ds_q - 4'd1;
    end
  end

  always_comb begin
    hprod = (WIDTH + 4)'(ps_q) * (WIDTH + 4)'(ds_q);
    hq    = hprod / (WIDTH + 4)'(10);
    dh_d  = (hq == '0) ? WIDTH'(1) : WIDTH'(hq);
  end

  assign duty_o = ds_q;
`else
  logic unused_duty;
  assign unused_duty = duty_up_i | duty_dn_i;

  always_comb begin
    dh_d = (ps_q[WIDTH-1:1] == '0) ? WIDTH'(1) : (ps_q >> 1);
  end

  assign duty_o = 4'd5;
`endif

  always_comb begin
    dp_d = ps_q;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      doff_d[k] = calc_off(ps_q, k);
    end
  end

  // While disabled the active set tracks the derived set so enabling starts fresh
  logic load;
  assign load = !en_i || (cnt_q == p_q - WIDTH'(1));

  always_comb begin
    p_d = p_q;
    h_d = h_q;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      off_d[k] = off_q[k];
    end
    if (load) begin
      p_d = dp_q;
      h_d = dh_q;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        off_d[k] = doff_q[k];
      end
    end
    cnt_d = (load) ? '0 : cnt_q + WIDTH'(1);
  end

  logic [WIDTH:0] diff;

  always_comb begin
    diff   = '0;
    wave_d = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (cnt_q >= off_q[k]) begin
        diff = {1'b0, cnt_q} - {1'b0, off_q[k]};
      end else begin
        diff = {1'b0, cnt_q} + {1'b0, p_q} - {1'b0, off_q[k]};
      end
      wave_d[k] = en_i && (diff < {1'b0, h_q});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q    <= InitP;
      mant_q  <= InitMant;
      limit_q <= 1'b0;
      dp_q    <= InitP;
      dh_q    <= InitH;
      p_q     <= InitP;
      h_q     <= InitH;
      cnt_q   <= '0;
      wave_q  <= '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        doff_q[k] <= calc_off(InitP, k);
        off_q[k]  <= calc_off(InitP, k);
      end
`ifdef SQWAVE_DUTY_EN
      ds_q    <= 4'd5;
`endif
    end else begin
      ps_q    <= ps_d;
      mant_q  <= mant_d;
      limit_q <= limit_d;
      dp_q    <= dp_d;
      dh_q    <= dh_d;
      p_q     <= p_d;
      h_q     <= h_d;
      cnt_q   <= cnt_d;
      wave_q  <= wave_d;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        doff_q[k] <= doff_d[k];
        off_q[k]  <= off_d[k];
      end
`ifdef SQWAVE_DUTY_EN
      ds_q    <= ds_d;
`endif
    end
  end

  assign wave_o   = wave_q;
  assign period_o = ps_q;
  assign mant_o   = mant_q;
  assign limit_o  = limit_q;

endmodule

// File: tb/tb_sqwave_gen.sv
// Directed bench for sqwave_gen: staged-value vector table plus waveform sequences.
module tb_sqwave_gen;

  localparam int unsigned W  = 32;
  localparam int unsigned CH = 2;
`ifdef SQWAVE_DUTY_EN
  localparam bit DutyEn = 1'b1;
`else
  localparam bit DutyEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b1;
  logic          fu  = 1'b0;
  logic          fd  = 1'b0;
  logic          du  = 1'b0;
  logic          dd  = 1'b0;
  logic [CH-1:0] wave;
  logic [W-1:0]  period;
  logic [1:0]    mant;
  logic [3:0]    duty;
  logic          limit;

  sqwave_gen #(
    .WIDTH      (W),
    .CHANNELS   (CH),
    .INIT_PERIOD(100),
    .INIT_MANT  (0),
    .MIN_PERIOD (5),
    .MAX_PERIOD (1000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en_i     (en),
    .freq_up_i(fu),
    .freq_dn_i(fd),
    .duty_up_i(du),
    .duty_dn_i(dd),
    .wave_o   (wave),
    .period_o (period),
    .mant_o   (mant),
    .duty_o   (duty),
    .limit_o  (limit)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    bit          rst;
    bit          fu;
    bit          fd;
    bit          du;
    bit          dd;
    int unsigned per;
    int unsigned mant;
    int unsigned duty;
    bit          lim;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT out of reset with cnt=0; the next step() yields sample 0 (cnt 0)
  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b1;
    fu  = 1'b0;
    fd  = 1'b0;
    du  = 1'b0;
    dd  = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Expected waves at P=100, H=50, two channels: sample index i reflects cnt i%100
  function automatic logic [1:0] model100(input int i);
    logic [1:0] e;
    e[0] = (i % 100) < 50;
    e[1] = (i % 100) >= 50;
    return e;
  endfunction

  task automatic measure(output int hi, output int per);
    int t;
    hi  = -1;
    per = -1;
    t = 0;
    while (wave[0] !== 1'b0 && t < 1000) begin step(); t++; end
    if (t >= 1000) return;
    t = 0;
    while (wave[0] !== 1'b1 && t < 1000) begin step(); t++; end
    if (t >= 1000) return;
    hi = 0;
    while (wave[0] === 1'b1 && hi < 2000) begin step(); hi++; end
    per = hi;
    while (wave[0] === 1'b0 && per < 2000) begin step(); per++; end
  endtask

  vec_t vecs [18];

  initial begin
    int mis;
    int hi;
    int per;
    logic [1:0] e;

    //        rst fu fd du dd  per  mant duty lim
    vecs[0]  = '{1, 1, 0, 0, 0,   50, 2, 5, 0};
    vecs[1]  = '{0, 1, 0, 0, 0,   20, 1, 5, 0};
    vecs[2]  = '{0, 1, 0, 0, 0,   10, 0, 5, 0};
    vecs[3]  = '{0, 1, 0, 0, 0,    5, 2, 5, 0};
    vecs[4]  = '{0, 1, 0, 0, 0,    5, 2, 5, 1};
    vecs[5]  = '{1, 0, 1, 0, 0,  200, 1, 5, 0};
    vecs[6]  = '{0, 0, 1, 0, 0,  500, 2, 5, 0};
    vecs[7]  = '{0, 0, 1, 0, 0, 1000, 0, 5, 0};
    vecs[8]  = '{0, 0, 1, 0, 0, 1000, 0, 5, 1};
    vecs[9]  = '{1, 1, 1, 0, 0,   50, 2, 5, 0};
    vecs[10] = '{0, 0, 0, 1, 0,   50, 2, 6, 0};
    vecs[11] = '{0, 0, 0, 1, 1,   50, 2, 7, 0};
    vecs[12] = '{0, 0, 0, 0, 1,   50, 2, 6, 0};
    vecs[13] = '{1, 0, 0, 0, 1,  100, 0, 4, 0};
    vecs[14] = '{0, 0, 0, 0, 1,  100, 0, 3, 0};
    vecs[15] = '{0, 0, 0, 0, 1,  100, 0, 2, 0};
    vecs[16] = '{0, 0, 0, 0, 1,  100, 0, 1, 0};
    vecs[17] = '{0, 0, 0, 0, 1,  100, 0, 1, 0};

    // Reset state
    step();
    step();
    chk("rst_wave", wave, 0);
    chk("rst_period", period, 100);
    chk("rst_mant", mant, 0);
    chk("rst_duty", duty, 5);
    chk("rst_limit", limit, 0);

    // Staged-value table
    for (int v = 0; v < 18; v++) begin
      if (vecs[v].rst) do_reset();
      fu = vecs[v].fu;
      fd = vecs[v].fd;
      du = vecs[v].du;
      dd = vecs[v].dd;
      step();
      fu = 1'b0;
      fd = 1'b0;
      du = 1'b0;
      dd = 1'b0;
      chk($sformatf("vec%0d_period", v), period, vecs[v].per);
      chk($sformatf("vec%0d_mant", v), mant, vecs[v].mant);
      chk($sformatf("vec%0d_duty", v), duty, DutyEn ? vecs[v].duty : 5);
      chk($sformatf("vec%0d_limit", v), limit, vecs[v].lim);
      step();
      chk($sformatf("vec%0d_limit_clr", v), limit, 0);
      repeat (3) step();
    end

    // Free run at P=100, then reset in mid-period
    do_reset();
    mis = 0;
    for (int i = 0; i < 330; i++) begin
      step();
      e = model100(i);
      if (wave !== e) mis++;
    end
    chk("run_p100_mis", mis, 0);
    rst = 1'b1;
    step();
    chk("rst_mid_wave", wave, 0);
    rst = 1'b0;
    mis = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      e = model100(i);
      if (wave !== e) mis++;
    end
    chk("after_rst_mis", mis, 0);

    // freq_up while cnt=10: current period completes, then P=50 with H=25, OFF1=25
    do_reset();
    mis = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 9) fu = 1'b1;
      if (i == 10) fu = 1'b0;
      if (i < 100) begin
        e = model100(i);
      end else begin
        e[0] = ((i - 100) % 50) < 25;
        e[1] = ((i - 100) % 50) >= 25;
      end
      if (wave !== e) mis++;
    end
    chk("step_cnt10_mis", mis, 0);
    chk("step_cnt10_period", period, 50);

    // Back-to-back duty steps, then high time at P=100
    do_reset();
    du = 1'b1;
    repeat (6) step();
    du = 1'b0;
    step();
    chk("duty_sat", duty, DutyEn ? 9 : 5);
    measure(hi, per);
    chk("duty_high", hi, DutyEn ? 90 : 50);
    chk("duty_period", per, 100);

    // Enable dropped for 37 cycles mid-period
    do_reset();
    mis = 0;
    for (int i = 0; i <= 30; i++) begin
      step();
      e = model100(i);
      if (wave !== e) mis++;
    end
    chk("pre_dis_mis", mis, 0);
    en = 1'b0;
    mis = 0;
    for (int i = 0; i < 37; i++) begin
      step();
      if (wave !== 2'b00) mis++;
    end
    chk("dis_wave_mis", mis, 0);
    en = 1'b1;
    mis = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      e = model100(i);
      if (wave !== e) mis++;
    end
    chk("reen_mis", mis, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
